// File: rtl/mrc_result_bcd_if.sv
// -----------------------------------------------------------------------------
// mrc_result_bcd_if
//   Bundle of signals between the MRC arithmetic unit (master) and the BCD
//   display stage mrc_result_bcd (slave).
//
//   Signals:
//     in_valid  MRC ready flag (level)                  master -> slave
//     Result    2*WORD_LENGTH-bit MRC result            master -> slave
//     error_in  MRC error flag, sampled with Result     master -> slave
//     busy      conversion in progress                  slave  -> master
//     done      one-cycle pulse when outputs update     slave  -> master
//     bcd_out   packed BCD, digit 0 in bits [3:0]       slave  -> master
//     err_out   last accepted Result carried an error   slave  -> master
//     sign_out  negative flag (signed build only)       slave  -> master
// -----------------------------------------------------------------------------
interface mrc_result_bcd_if #(
    parameter int WORD_LENGTH = 16,
    parameter int DIGITS      = 10
);
    logic                       in_valid;
    logic [2*WORD_LENGTH-1:0]   Result;
    logic                       error_in;
    logic                       busy;
    logic                       done;
    logic [4*DIGITS-1:0]        bcd_out;
    logic                       err_out;
    logic                       sign_out;

    modport master (
        output in_valid, Result, error_in,
        input  busy, done, bcd_out, err_out, sign_out
    );

    modport slave (
        input  in_valid, Result, error_in,
        output busy, done, bcd_out, err_out, sign_out
    );
endinterface

// File: rtl/mrc_result_bcd.sv
// -----------------------------------------------------------------------------
// mrc_result_bcd
//   Display stage for the MRC arithmetic unit. On each rising edge of the MRC
//   ready flag (accepted only while idle) the 2*WORD_LENGTH-bit Result is
//   converted to packed BCD with an iterative double-dabble (shift-and-add-3),
//   one bit per clock. The digits are held on bcd_out for the seven-segment
//   decoders until the next conversion completes.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high reset
//     bus    mrc_result_bcd_if.slave (in_valid, Result, error_in in;
//            busy, done, bcd_out, err_out, sign_out out)
//
//   Latency: done at edge k+2*WORD_LENGTH+1 after the accepting edge k,
//            or k+1 when error_in was set (bcd_out blanked to all 0xF).
//
//   Build option: define MRC_BCD_SIGNED_EN to treat Result as two's
//   complement; the magnitude is converted and sign_out flags negatives.
//   Without it sign_out is constant 0 and no negation logic exists.
// -----------------------------------------------------------------------------
module mrc_result_bcd #(
    parameter int WORD_LENGTH = 16,
    parameter int DIGITS      = 10
) (
    input  logic             clk,
    input  logic             reset,
    mrc_result_bcd_if.slave  bus
);
    localparam int BIN_W = 2 * WORD_LENGTH;
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state_reg,     state_next;
    logic [BIN_W-1:0]   shreg_reg,     shreg_next;
    logic [BCD_W-1:0]   digits_reg,    digits_next;
    logic [CNT_W-1:0]   cnt_reg,       cnt_next;
    logic               err_cap_reg,   err_cap_next;
    logic               sign_cap_reg,  sign_cap_next;
    logic               busy_reg,      busy_next;
    logic               done_reg,      done_next;
    logic [BCD_W-1:0]   bcd_reg,       bcd_next;
    logic               err_out_reg,   err_out_next;
    logic               sign_out_reg,  sign_out_next;
    logic               in_valid_d_reg;

    logic               trigger;
    logic [BIN_W-1:0]   magnitude;
    logic               sign_in;
    logic [BCD_W-1:0]   digits_adj;

    // Rising edge of the ready level; holding ready high yields one start.
    assign trigger = bus.in_valid & ~in_valid_d_reg;

`ifdef MRC_BCD_SIGNED_EN
    // Two's complement negate; the most negative value maps onto itself,
    // which read as unsigned is exactly 2^(BIN_W-1).
    assign sign_in   = bus.Result[BIN_W-1];
    assign magnitude = sign_in ? (~bus.Result + BIN_W'(1)) : bus.Result;
`else
    assign sign_in   = 1'b0;
    assign magnitude = bus.Result;
`endif

    // Add-3 correction: any digit >= 5 would overflow past 9 after doubling.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_add3
            assign digits_adj[4*gi +: 4] = (digits_reg[4*gi +: 4] >= 4'd5)
                                         ? digits_reg[4*gi +: 4] + 4'd3
                                         : digits_reg[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            shreg_reg      <= '0;
            digits_reg     <= '0;
            cnt_reg        <= '0;
            err_cap_reg    <= 1'b0;
            sign_cap_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            bcd_reg        <= '0;
            err_out_reg    <= 1'b0;
            sign_out_reg   <= 1'b0;
            in_valid_d_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shreg_reg      <= shreg_next;
            digits_reg     <= digits_next;
            cnt_reg        <= cnt_next;
            err_cap_reg    <= err_cap_next;
            sign_cap_reg   <= sign_cap_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            bcd_reg        <= bcd_next;
            err_out_reg    <= err_out_next;
            sign_out_reg   <= sign_out_next;
            in_valid_d_reg <= bus.in_valid;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shreg_next    = shreg_reg;
        digits_next   = digits_reg;
        cnt_next      = cnt_reg;
        err_cap_next  = err_cap_reg;
        sign_cap_next = sign_cap_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        bcd_next      = bcd_reg;
        err_out_next  = err_out_reg;
        sign_out_next = sign_out_reg;

        case (state_reg)
            IDLE: begin
                if (trigger) begin
                    shreg_next    = magnitude;
                    err_cap_next  = bus.error_in;
                    sign_cap_next = sign_in;
                    digits_next   = '0;
                    cnt_next      = CNT_W'(BIN_W);
                    busy_next     = 1'b1;
                    // An errored result is never converted; go straight to
                    // publishing the blank code.
                    state_next    = bus.error_in ? FINISH : SHIFT;
                end
            end

            SHIFT: begin
                {digits_next, shreg_next} = {digits_adj, shreg_reg} << 1;
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = FINISH;
                end
            end

            FINISH: begin
                bcd_next      = err_cap_reg ? {BCD_W{1'b1}} : digits_reg;
                err_out_next  = err_cap_reg;
                sign_out_next = sign_cap_reg & ~err_cap_reg;
                done_next     = 1'b1;
                busy_next     = 1'b0;
                state_next    = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.bcd_out  = bcd_reg;
    assign bus.err_out  = err_out_reg;
    assign bus.sign_out = sign_out_reg;
endmodule

// File: tb/tb_mrc_result_bcd.sv
// -----------------------------------------------------------------------------
// tb_mrc_result_bcd
//   Directed bench for mrc_result_bcd with hand-computed BCD expectations.
//   Expected values for the signed build are selected with MRC_BCD_SIGNED_EN.
// -----------------------------------------------------------------------------
module tb_mrc_result_bcd;
    localparam int WL  = 16;
    localparam int DG  = 10;
    localparam int LAT = 2 * WL + 1;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mrc_result_bcd_if #(.WORD_LENGTH(WL), .DIGITS(DG)) bus ();

    mrc_result_bcd #(.WORD_LENGTH(WL), .DIGITS(DG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drop in_valid for one cycle, present the operands with a fresh rising
    // edge, and return just after the accepting edge k.
    task automatic start(input logic [31:0] res, input logic err);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        bus.Result   = res;
        bus.error_in = err;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    // Count edges after k until done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done) break;
        end
    endtask

    task automatic convert(input string tag, input logic [31:0] res, input logic err,
                           input logic [39:0] exp_bcd, input logic exp_err,
                           input logic exp_sign, input int exp_lat);
        int lat;
        start(res, err);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
        bus.Result = 32'h1234_5678;      // Result need not stay stable
        wait_done(lat);
        chk({tag, "_lat"},  64'(lat), 64'(exp_lat));
        chk({tag, "_bcd"},  64'(bus.bcd_out), 64'(exp_bcd));
        chk({tag, "_err"},  64'(bus.err_out), 64'(exp_err));
        chk({tag, "_sign"}, 64'(bus.sign_out), 64'(exp_sign));
        chk({tag, "_nbusy"}, 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 64'(bus.done), 64'd0);
        chk({tag, "_hold"},  64'(bus.bcd_out), 64'(exp_bcd));
        $display("conv %s: Result=%h err=%0d -> bcd=%h err_out=%0d sign=%0d lat=%0d",
                 tag, res, err, bus.bcd_out, bus.err_out, bus.sign_out, lat);
    endtask

    initial begin
        int ndone;
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.Result   = '0;
        bus.error_in = 1'b0;

        // Power-up reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_bcd",  64'(bus.bcd_out), 64'd0);
        chk("rst_err",  64'(bus.err_out), 64'd0);
        chk("rst_sign", 64'(bus.sign_out), 64'd0);
        $display("reset: busy=%0d done=%0d bcd=%h", bus.busy, bus.done, bus.bcd_out);
        reset = 1'b0;

        convert("c625", 32'd625, 1'b0, 40'h00_0000_0625, 1'b0, 1'b0, LAT);
`ifdef MRC_BCD_SIGNED_EN
        convert("cmax", 32'hFFFF_FFFF, 1'b0, 40'h00_0000_0001, 1'b0, 1'b1, LAT);
`else
        convert("cmax", 32'hFFFF_FFFF, 1'b0, 40'h42_9496_7295, 1'b0, 1'b0, LAT);
`endif
        convert("czero", 32'd0, 1'b0, 40'h00_0000_0000, 1'b0, 1'b0, LAT);
        convert("cerr", 32'd25, 1'b1, 40'hFF_FFFF_FFFF, 1'b1, 1'b0, 1);
        convert("c25",  32'd25, 1'b0, 40'h00_0000_0025, 1'b0, 1'b0, LAT);
`ifdef MRC_BCD_SIGNED_EN
        convert("cneg",  32'hFFFF_FFE7, 1'b0, 40'h00_0000_0025, 1'b0, 1'b1, LAT);
        convert("cmin",  32'h8000_0000, 1'b0, 40'h21_4748_3648, 1'b0, 1'b1, LAT);
        convert("cnerr", 32'hFFFF_FFE7, 1'b1, 40'hFF_FFFF_FFFF, 1'b1, 1'b0, 1);
`else
        convert("c2p31", 32'h8000_0000, 1'b0, 40'h21_4748_3648, 1'b0, 1'b0, LAT);
`endif

        // Mid-conversion asynchronous reset: outputs clear at once, no done.
        start(32'd12345, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_busy", 64'(bus.busy), 64'd0);
        chk("mid_done", 64'(bus.done), 64'd0);
        chk("mid_bcd",  64'(bus.bcd_out), 64'd0);
        chk("mid_err",  64'(bus.err_out), 64'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        reset        = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        chk("mid_nodone", 64'(ndone), 64'd0);
        $display("midreset: bcd=%h done_pulses=%0d", bus.bcd_out, ndone);

        // Level held high with a second rising edge at k+10: one conversion.
        @(posedge clk); #1;
        bus.Result   = 32'd7;
        bus.error_in = 1'b0;
        bus.in_valid = 1'b1;
        ndone = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (i == 9)  bus.in_valid = 1'b0;
            if (i == 10) bus.in_valid = 1'b1;
            if (bus.done) ndone++;
        end
        chk("hold_ndone", 64'(ndone), 64'd1);
        chk("hold_bcd",   64'(bus.bcd_out), 64'h7);
        $display("hold: done_pulses=%0d bcd=%h", ndone, bus.bcd_out);

        // Fresh edge after done starts a new conversion.
        convert("c99", 32'd99, 1'b0, 40'h00_0000_0099, 1'b0, 1'b0, LAT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
